io_bus_responder: RTL and testbench
===================================

Name: io_bus_responder

Overview:
- Data-side responder behind the single-cycle miniRV core's load/store interface.
- Decodes every CPU data access and performs one of two actions:
  - forwards it to DRAM, or
  - services it from memory-mapped I/O registers (8-digit seven-segment display, 24 LEDs, 24 switches).
- Returns read data combinationally, so a load completes in the same cycle it is issued.
- Owns the seven-segment scan timing and input synchronisation.

Parameters:
- SCAN_DIV, 50000: cpu_clk cycles each digit stays lit; legal range ≥2.
- DEB_CYCLES, 20000: consecutive stable samples required before a button change is accepted (used only with BTN_DEBOUNCE_EN).

Ports:
- cpu_clk  in  1  sole clock.
- cpu_rst_n  in  1  asynchronous active-low reset.
- addr  in  32  CPU data address (ALU result).
- wdata  in  32  CPU store data.
- we  in  1  CPU store enable.
- rdata  out  32  load data returned to the CPU.
- dram_addr  out  14  word address to DRAM, equal to addr[15:2].
- dram_wdata  out  32  equal to wdata.
- dram_we  out  1  DRAM write enable.
- dram_rdata  in  32  DRAM combinational read data.
- sw  in  24  board switches, asynchronous.
- led  out  24  board LEDs, active-high.
- dig_en  out  8  digit enables, active-low; bit 0 is the rightmost digit.
- dig_seg  out  8  segments {DP,G,F,E,D,C,B,A}, active-low.
- btn  in  5  push buttons, asynchronous; present only with BTN_DEBOUNCE_EN.

Behaviour:
- Address decode:
  - io_sel = (addr[31:12] == 20'hFFFFF); decode is combinational.
  - io_sel=0: dram_we=we and rdata=dram_rdata.
  - io_sel=1: dram_we=0 and rdata comes from the I/O map.
- I/O map (full 32-bit match):
  - 0xFFFFF000 DIG: read/write 32-bit register; nibble i drives digit i.
  - 0xFFFFF060 LED: read/write; wdata[23:0] is stored; reads return {8'h0,led}.
  - 0xFFFFF070 SW: read-only; returns {8'h0,sw_sync}; writes are ignored.
  - 0xFFFFF078 BTN: read-only; returns {27'h0,btn_stable}, or 0 when BTN_DEBOUNCE_EN is off.
  - Any other I/O address: reads return 0; writes are ignored with no side effects.
- Writes:
  - A register is updated on the rising cpu_clk edge when we=1 and the address matches.
  - A load issued in the cycle after a write returns the new value.
- Switch path:
  - Two-flop synchroniser on sw.
  - A SW read reflects the pin value from 2 cycles earlier.
- Scanner:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps; a tick occurs on the cycle scan_cnt==SCAN_DIV-1.
  - idx (3 bits) increments on each tick and wraps 7→0.
  - On a tick, the following are registered:
    - dig_en <= ~(8'b1<<(idx+1));
    - dig_seg <= {1'b1, hex7(DIG[4*(idx+1)+:4])}.
  - Exactly one dig_en bit is low at any time after the first tick.
  - A DIG write on a tick edge is not visible until the next tick, because the tick samples the pre-write register value.
- hex7 (active-low, DP off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E
- Reset (asynchronous, any time including mid-scan or mid-debounce):
  - DIG=0, led=0, sw_sync=0, scan_cnt=0, idx=0.
  - dig_en=8'hFF and dig_seg=8'hFF (display dark until the first tick).
  - Debounce state=0.
  - rdata and dram_* remain combinational from inputs.
- Simultaneous events:
  - A store and a tick in the same cycle are independent and both take effect.
  - we=1 with io_sel=1 never reaches DRAM.

Optional Feature:
- Macro: BTN_DEBOUNCE_EN.
- Defined:
  - btn port exists.
  - Each bit is two-flop synchronised and then debounced by a per-bit counter.
  - btn_stable[i] changes only after DEB_CYCLES consecutive cycles in which the synchronised input differs from btn_stable[i].
  - Any sample equal to btn_stable[i] clears counter[i].
  - The stable value is read at 0xFFFFF078.
- Undefined:
  - btn port and all debounce logic are absent.
  - 0xFFFFF078 reads 0.

Test Plan:
- Apply reset, then store 0x12345678 to 0xFFFFF000 with SCAN_DIV=4 → dig_en=FF until the first tick; after the tick dig_en=FD and dig_seg=F8 (digit 1 = "7"); 4 cycles later dig_en=FB and dig_seg=82 ("6"); idx wraps 7→0 with dig_en=FE and dig_seg=80 ("8").
- Store 0xFFABCDEF to 0xFFFFF060 → led=ABCDEF, dram_we=0 in that cycle, and a next-cycle load returns 0x00ABCDEF.
- Set sw=0x5A5A5A → a load from 0xFFFFF070 returns 0 for cycles 0-1 and 0x005A5A5A from cycle 2; a store to 0xFFFFF070 changes nothing.
- Store 0xDEADBEEF to 0x00000010, then load it → dram_we=1, dram_addr=4, rdata=dram_rdata; load from 0xFFFFF100 → rdata=0.
- Assert cpu_rst_n=0 mid-scan with led=0xFF → led, DIG, dig_en and dig_seg all return to reset values immediately, without waiting for a clock edge.
- BTN_DEBOUNCE_EN, DEB_CYCLES=8: a 5-cycle pulse on btn[0] → read 0; an 8+ cycle press → reads 1 after sync latency plus 8 cycles.

Source files
------------

// File: rtl/io_bus_responder.sv
// Data-side load/store responder for the miniRV core: DRAM forwarding plus MMIO display, LED, switch and button registers.
// Optional build macro BTN_DEBOUNCE_EN adds the btn port and per-bit debouncers at 0xFFFFF078.
module io_bus_responder #(
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_CYCLES = 20000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic [13:0] dram_addr,
    output logic [31:0] dram_wdata,
    output logic        dram_we,
    input  logic [31:0] dram_rdata,
    input  logic [23:0] sw,
    output logic [23:0] led,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg
`ifdef BTN_DEBOUNCE_EN
    ,
    input  logic [4:0]  btn
`endif
);
    localparam logic [31:0] ADDR_DIG = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_LED = 32'hFFFF_F060;
    localparam logic [31:0] ADDR_SW  = 32'hFFFF_F070;
    localparam logic [31:0] ADDR_BTN = 32'hFFFF_F078;
    localparam int          SCAN_W   = $clog2(SCAN_DIV);

    if (SCAN_DIV < 2 || DEB_CYCLES < 1) begin : g_bad_param
        $error("io_bus_responder: SCAN_DIV must be >= 2 and DEB_CYCLES >= 1");
    end

    // Bus timing: there is no handshake. Every access completes in the cycle it is
    // issued: decode and read data are combinational, stores commit on the next rising edge.
    logic        io_sel;
    logic [31:0] io_rdata;
    logic [31:0] dig_reg;
    logic [23:0] sw_meta, sw_sync;
    logic [4:0]  btn_stable;

    assign io_sel     = (addr[31:12] == 20'hFFFFF);
    assign dram_addr  = addr[15:2];
    assign dram_wdata = wdata;
    assign dram_we    = we & ~io_sel;

    always_comb begin
        io_rdata = '0;
        case (addr)
            ADDR_DIG: io_rdata = dig_reg;
            ADDR_LED: io_rdata = {8'h0, led};
            ADDR_SW:  io_rdata = {8'h0, sw_sync};
            ADDR_BTN: io_rdata = {27'h0, btn_stable};
            default:  io_rdata = '0;
        endcase
        rdata = io_sel ? io_rdata : dram_rdata;
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            dig_reg <= '0;
            led     <= '0;
        end else if (we && io_sel) begin
            if (addr == ADDR_DIG) dig_reg <= wdata;
            if (addr == ADDR_LED) led <= wdata[23:0];
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    // Seven-segment scanner: the digit after idx is loaded on each tick, so the
    // display stays dark from reset until the first tick.
    logic [SCAN_W-1:0] scan_cnt;
    logic [2:0]        idx;
    logic [2:0]        idx_nxt;
    logic              tick;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    assign tick    = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign idx_nxt = idx + 3'd1;

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
            dig_en   <= 8'hFF;
            dig_seg  <= 8'hFF;
        end else begin
            scan_cnt <= tick ? '0 : scan_cnt + 1'b1;
            if (tick) begin
                idx     <= idx_nxt;
                dig_en  <= ~(8'b1 << idx_nxt);
                dig_seg <= {1'b1, hex7(dig_reg[{idx_nxt, 2'b00} +: 4])};
            end
        end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    logic [4:0]       btn_meta, btn_sync;
    logic [DEB_W-1:0] deb_cnt [5];

    // A counter runs only while the synchronised input disagrees with the stable value.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            btn_meta   <= '0;
            btn_sync   <= '0;
            btn_stable <= '0;
            for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
        end else begin
            btn_meta <= btn;
            btn_sync <= btn_meta;
            for (int i = 0; i < 5; i++) begin
                if (btn_sync[i] == btn_stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    btn_stable[i] <= btn_sync[i];
                    deb_cnt[i]    <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign btn_stable = '0;
`endif

endmodule

// File: tb/tb_io_bus_responder.sv
// Self-checking bench for io_bus_responder: directed bring-up sequence followed by randomized
// bus traffic, checked by a negedge monitor against a cycle-level model of the register map.
module tb_io_bus_responder;
    localparam int SCAN_DIV   = 4;
    localparam int DEB_CYCLES = 8;
    localparam int N_RAND     = 400;

    localparam logic [31:0] A_DIG = 32'hFFFF_F000;
    localparam logic [31:0] A_LED = 32'hFFFF_F060;
    localparam logic [31:0] A_SW  = 32'hFFFF_F070;
    localparam logic [31:0] A_BTN = 32'hFFFF_F078;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst_n;
    logic [31:0] addr, wdata, rdata, dram_wdata, dram_rdata;
    logic        we, dram_we;
    logic [13:0] dram_addr;
    logic [23:0] sw, led;
    logic [7:0]  dig_en, dig_seg;
`ifdef BTN_DEBOUNCE_EN
    logic [4:0]  btn;
`endif

    io_bus_responder #(.SCAN_DIV(SCAN_DIV), .DEB_CYCLES(DEB_CYCLES)) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst_n (cpu_rst_n),
        .addr      (addr),
        .wdata     (wdata),
        .we        (we),
        .rdata     (rdata),
        .dram_addr (dram_addr),
        .dram_wdata(dram_wdata),
        .dram_we   (dram_we),
        .dram_rdata(dram_rdata),
        .sw        (sw),
        .led       (led),
        .dig_en    (dig_en),
        .dig_seg   (dig_seg)
`ifdef BTN_DEBOUNCE_EN
        ,
        .btn       (btn)
`endif
    );

    // ---------------- clock / environment ----------------
    always #5 cpu_clk = ~cpu_clk;

    // Small DRAM stand-in; the bench only uses word addresses below 256 for data.
    logic [31:0] dram [256];
    assign dram_rdata = dram[dram_addr[7:0]];
    always @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            for (int i = 0; i < 256; i++) dram[i] <= '0;
        end else if (dram_we) begin
            dram[dram_addr[7:0]] <= dram_wdata;
        end
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int          sig_q[$];
    string       name_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [31:0] dut_sig(input int s);
        case (s)
            0: return rdata;
            1: return {8'h0, led};
            2: return {24'h0, dig_en};
            3: return {24'h0, dig_seg};
            4: return {31'h0, dram_we};
            5: return {18'h0, dram_addr};
            6: return dram_wdata;
            default: return 32'hx;
        endcase
    endfunction

    task automatic exp_push(input int s, input logic [31:0] v, input string n);
        exp_q.push_back(v);
        sig_q.push_back(s);
        name_q.push_back(n);
    endtask

    always @(negedge cpu_clk) begin : monitor
        logic [31:0] e, a;
        int          s;
        string       n;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            s = sig_q.pop_front();
            n = name_q.pop_front();
            a = dut_sig(s);
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s @%0t: got %h expected %h", n, $time, a, e);
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] m_dig;
    logic [23:0] m_led, m_sw_sync, m_sw_pin1;
    logic [7:0]  m_en, m_seg;
    logic [31:0] m_mem [256];
    int          m_edges, m_ticks;
    logic [4:0]  m_btn_stable, m_btn_sync, m_btn_pin1;
    int          m_btn_run [5];

    function automatic logic [7:0] hex8(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
            4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
            4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
            4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
        endcase
    endfunction

    task automatic model_reset();
        m_dig = '0; m_led = '0; m_sw_sync = '0; m_sw_pin1 = '0;
        m_en = 8'hFF; m_seg = 8'hFF; m_edges = 0; m_ticks = 0;
        m_btn_stable = '0; m_btn_sync = '0; m_btn_pin1 = '0;
        for (int i = 0; i < 5; i++) m_btn_run[i] = 0;
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:12] != 20'hFFFFF) return m_mem[a[9:2]];
        if (a == A_DIG) return m_dig;
        if (a == A_LED) return {8'h0, m_led};
        if (a == A_SW)  return {8'h0, m_sw_sync};
`ifdef BTN_DEBOUNCE_EN
        if (a == A_BTN) return {27'h0, m_btn_stable};
`endif
        return 32'h0;
    endfunction

    // One rising edge of the world: display tick (sees pre-write DIG), store, input sampling.
    task automatic model_edge();
        int k;
        m_edges++;
        if (m_edges % SCAN_DIV == 0) begin
            m_ticks++;
            k     = m_ticks % 8;
            m_en  = ~(8'd1 << k);
            m_seg = hex8(m_dig[4*k +: 4]);
        end
        if (we && addr[31:12] == 20'hFFFFF) begin
            if (addr == A_DIG) m_dig = wdata;
            if (addr == A_LED) m_led = wdata[23:0];
        end
        if (we && addr[31:12] != 20'hFFFFF) m_mem[addr[9:2]] = wdata;
        m_sw_sync = m_sw_pin1;
        m_sw_pin1 = sw;
`ifdef BTN_DEBOUNCE_EN
        for (int i = 0; i < 5; i++) begin
            if (m_btn_sync[i] != m_btn_stable[i]) begin
                m_btn_run[i]++;
                if (m_btn_run[i] == DEB_CYCLES) begin
                    m_btn_stable[i] = m_btn_sync[i];
                    m_btn_run[i]    = 0;
                end
            end else begin
                m_btn_run[i] = 0;
            end
        end
        m_btn_sync = m_btn_pin1;
        m_btn_pin1 = btn;
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w);
        addr = a; wdata = d; we = w;
    endtask

    task automatic push_model();
        exp_push(0, model_read(addr), "rdata");
        exp_push(1, {8'h0, m_led}, "led");
        exp_push(2, {24'h0, m_en}, "dig_en");
        exp_push(3, {24'h0, m_seg}, "dig_seg");
        exp_push(4, {31'h0, we && (addr[31:12] != 20'hFFFFF)}, "dram_we");
        exp_push(5, {18'h0, addr[15:2]}, "dram_addr");
        exp_push(6, wdata, "dram_wdata");
    endtask

    task automatic advance();
        @(posedge cpu_clk);
        if (cpu_rst_n) model_edge();
        #1;
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] d, input logic w);
        drive(a, d, w);
        push_model();
        advance();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a, d;
        logic        w;
        int          r;

        cpu_rst_n = 1'b0;
        addr = '0; wdata = '0; we = 1'b0; sw = '0;
`ifdef BTN_DEBOUNCE_EN
        btn = '0;
`endif
        model_reset();
        repeat (3) @(posedge cpu_clk);
        #1;
        drive(A_DIG, 32'h0, 1'b0);
        exp_push(2, 32'hFF, "reset_dig_en");
        exp_push(3, 32'hFF, "reset_dig_seg");
        push_model();
        advance();
        cpu_rst_n = 1'b1;
        model_reset();

        // Display bring-up with SCAN_DIV=4: ticks land on edges 4, 8, ... 32.
        op(A_DIG, 32'h1234_5678, 1'b1);
        drive(32'h0, 32'h0, 1'b0);
        exp_push(2, 32'hFF, "dark_before_tick");
        push_model();
        advance();
        op(32'h0, 32'h0, 1'b0);
        op(32'h0, 32'h0, 1'b0);
        drive(32'h0, 32'h0, 1'b0);
        exp_push(2, 32'hFD, "tick1_dig_en");
        exp_push(3, 32'hF8, "tick1_dig_seg");
        push_model();
        advance();
        repeat (3) op(32'h0, 32'h0, 1'b0);
        drive(32'h0, 32'h0, 1'b0);
        exp_push(2, 32'hFB, "tick2_dig_en");
        exp_push(3, 32'h82, "tick2_dig_seg");
        push_model();
        advance();
        repeat (23) op(32'h0, 32'h0, 1'b0);
        drive(32'h0, 32'h0, 1'b0);
        exp_push(2, 32'hFE, "wrap_dig_en");
        exp_push(3, 32'h80, "wrap_dig_seg");
        push_model();
        advance();

        // LED store and read-back
        drive(A_LED, 32'hFFAB_CDEF, 1'b1);
        exp_push(4, 32'h0, "led_store_dram_we");
        push_model();
        advance();
        drive(A_LED, 32'h0, 1'b0);
        exp_push(0, 32'h00AB_CDEF, "led_readback");
        exp_push(1, 32'h00AB_CDEF, "led_pins");
        push_model();
        advance();

        // Switch synchroniser latency, then an ignored store
        drive(A_SW, 32'h0, 1'b0);
        sw = 24'h5A5A5A;
        exp_push(0, 32'h0, "sw_cycle0");
        push_model();
        advance();
        drive(A_SW, 32'h0, 1'b0);
        exp_push(0, 32'h0, "sw_cycle1");
        push_model();
        advance();
        drive(A_SW, 32'h0, 1'b0);
        exp_push(0, 32'h005A_5A5A, "sw_cycle2");
        push_model();
        advance();
        op(A_SW, 32'hFFFF_FFFF, 1'b1);
        drive(A_SW, 32'h0, 1'b0);
        exp_push(0, 32'h005A_5A5A, "sw_after_store");
        push_model();
        advance();

        // DRAM forwarding and unmapped I/O
        drive(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
        exp_push(4, 32'h1, "dram_store_we");
        exp_push(5, 32'h4, "dram_store_addr");
        exp_push(6, 32'hDEAD_BEEF, "dram_store_wdata");
        push_model();
        advance();
        drive(32'h0000_0010, 32'h0, 1'b0);
        exp_push(0, 32'hDEAD_BEEF, "dram_load");
        push_model();
        advance();
        op(32'hFFFF_F100, 32'h1234_5678, 1'b1);
        drive(32'hFFFF_F100, 32'h0, 1'b0);
        exp_push(0, 32'h0, "unmapped_read");
        push_model();
        advance();
        drive(32'h0000_FFFC, 32'h0, 1'b0);
        exp_push(5, 32'h3FFF, "dram_addr_top");
        push_model();
        advance();
        op(A_LED, 32'h0, 1'b0);
        op(A_DIG, 32'h0, 1'b0);

`ifdef BTN_DEBOUNCE_EN
        // Short pulse must be rejected, a long press accepted after 2 + DEB_CYCLES edges.
        btn = 5'b00001;
        repeat (5) op(A_BTN, 32'h0, 1'b0);
        btn = 5'b00000;
        repeat (12) op(A_BTN, 32'h0, 1'b0);
        drive(A_BTN, 32'h0, 1'b0);
        exp_push(0, 32'h0, "btn_pulse_rejected");
        push_model();
        advance();
        btn = 5'b00001;
        repeat (10) op(A_BTN, 32'h0, 1'b0);
        drive(A_BTN, 32'h0, 1'b0);
        exp_push(0, 32'h1, "btn_press_accepted");
        push_model();
        advance();
        btn = 5'b00000;
        repeat (12) op(A_BTN, 32'h0, 1'b0);
`endif

        // Asynchronous reset mid-scan: outputs clear before any clock edge.
        op(A_LED, 32'h0000_00FF, 1'b1);
        repeat (2) op(32'h0, 32'h0, 1'b0);
        cpu_rst_n = 1'b0;
        model_reset();
        drive(A_DIG, 32'h0, 1'b0);
        exp_push(1, 32'h0, "async_reset_led");
        exp_push(0, 32'h0, "async_reset_dig");
        exp_push(2, 32'hFF, "async_reset_dig_en");
        exp_push(3, 32'hFF, "async_reset_dig_seg");
        push_model();
        advance();
        advance();
        cpu_rst_n = 1'b1;
        model_reset();

        // Randomized traffic over the whole map
        for (int i = 0; i < N_RAND; i++) begin
            r = $urandom_range(0, 9);
            d = $urandom;
            w = 1'($urandom_range(0, 1));
            case (r)
                0:       a = A_DIG;
                1:       a = A_LED;
                2:       a = A_SW;
                3:       a = A_BTN;
                4:       a = 32'hFFFF_F000 | (32'($urandom_range(0, 1023)) << 2);
                5, 6, 7: a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                default: begin
                    a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                    w = 1'b0;
                end
            endcase
            if ($urandom_range(0, 7) == 0) sw = 24'($urandom);
`ifdef BTN_DEBOUNCE_EN
            if ($urandom_range(0, 15) == 0) btn = 5'($urandom);
`endif
            op(a, d, w);
        end

        drive(32'h0, 32'h0, 1'b0);
        @(negedge cpu_clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
